// File: rtl/hazard_forward_unit.sv
// Operand forwarding selects plus load-use stall controller for the pipelined MIPS core.
// Forwarding is purely combinational; the stall FSM holds PC/IF-ID and bubbles ID/EX for LOAD_LAT cycles.
module hazard_forward_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]  ex_src_addr,
  input  logic [NUM_FWD-1:0]         fwd_wr_en,
  input  logic [NUM_FWD*REG_AW-1:0]  fwd_wr_addr,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  input  logic [NUM_SRC*REG_AW-1:0]  id_src_addr,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic                       ex_is_load,
  input  logic                       ex_wr_en,
  input  logic [REG_AW-1:0]          ex_wr_addr,
  input  logic                       flush,
  output logic                       pc_hold,
  output logic                       ifid_hold,
  output logic                       idex_bubble,
  output logic [CNT_W-1:0]           stall_count
);

  localparam int REM_W = $clog2(LOAD_LAT) + 1;

  typedef enum logic [0:0] {IDLE, STALL} state_t;

  state_t           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             haz;
  logic             src_hit;
  logic             stall;

  // Scanning oldest to youngest lets the youngest matching producer overwrite older ones.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_src_addr[i*REG_AW +: REG_AW] != '0) begin
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
          if (fwd_wr_en[k] && (fwd_wr_addr[k*REG_AW +: REG_AW] == ex_src_addr[i*REG_AW +: REG_AW]))
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && (id_src_addr[i*REG_AW +: REG_AW] == ex_wr_addr))
        src_hit = 1'b1;
    end
    haz = ex_is_load && ex_wr_en && (ex_wr_addr != '0) && src_hit;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    if (flush) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          stall = haz;
          if (haz && (LOAD_LAT > 1)) begin
            state_d = STALL;
            rem_d   = REM_W'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          stall = 1'b1;
          if (rem_q == REM_W'(1)) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
    // Holds must drop the instant reset asserts, not at the next edge.
    stall = stall && rst_n;
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pc_hold     = stall;
  assign ifid_hold   = stall;
  assign idex_bubble = stall;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: a driver pushes model predictions, a monitor pops and compares.
// A second instance with a 2-bit counter shares the stimulus to exercise counter saturation.
module tb_hazard_forward_unit;

  localparam int LOAD_LAT = 2;

  typedef struct packed {
    logic       rst_n;
    logic [9:0] ex_src;
    logic [1:0] wr_en;
    logic [9:0] wr_addr;
    logic [9:0] id_src;
    logic [1:0] id_used;
    logic       ex_is_load;
    logic       ex_wr_en;
    logic [4:0] ex_wr_addr;
    logic       flush;
  } stim_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic        stall;
    logic [15:0] cnt;
    logic [1:0]  cnt_sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  ex_src_addr = '0;
  logic [1:0]  fwd_wr_en = '0;
  logic [9:0]  fwd_wr_addr = '0;
  logic [9:0]  id_src_addr = '0;
  logic [1:0]  id_src_used = '0;
  logic        ex_is_load = 1'b0;
  logic        ex_wr_en = 1'b0;
  logic [4:0]  ex_wr_addr = '0;
  logic        flush = 1'b0;

  logic [3:0]  fwd_sel, sat_fwd_sel;
  logic        pc_hold, ifid_hold, idex_bubble;
  logic        sat_pc_hold, sat_ifid_hold, sat_idex_bubble;
  logic [15:0] stall_count;
  logic [1:0]  sat_stall_count;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_left = 0;
  int   model_count = 0;
  bit   driver_done = 1'b0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.LOAD_LAT(LOAD_LAT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_src_addr(ex_src_addr), .fwd_wr_en(fwd_wr_en),
    .fwd_wr_addr(fwd_wr_addr), .fwd_sel(fwd_sel), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .ex_is_load(ex_is_load), .ex_wr_en(ex_wr_en),
    .ex_wr_addr(ex_wr_addr), .flush(flush), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .idex_bubble(idex_bubble), .stall_count(stall_count)
  );

  hazard_forward_unit #(.LOAD_LAT(LOAD_LAT), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ex_src_addr(ex_src_addr), .fwd_wr_en(fwd_wr_en),
    .fwd_wr_addr(fwd_wr_addr), .fwd_sel(sat_fwd_sel), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .ex_is_load(ex_is_load), .ex_wr_en(ex_wr_en),
    .ex_wr_addr(ex_wr_addr), .flush(flush), .pc_hold(sat_pc_hold), .ifid_hold(sat_ifid_hold),
    .idex_bubble(sat_idex_bubble), .stall_count(sat_stall_count)
  );

  // Reference forwarding: first (youngest) producer writing the same nonzero register wins.
  function automatic logic [3:0] modelSel(input stim_t s);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      logic [4:0] a;
      bit found;
      a = s.ex_src[i*5 +: 5];
      found = 1'b0;
      if (a != 5'd0) begin
        for (int k = 0; k < 2; k++) begin
          if (!found && s.wr_en[k] && s.wr_addr[k*5 +: 5] == a) begin
            r[i*2 +: 2] = 2'(k + 1);
            found = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  // Reference stall: a hazard buys LOAD_LAT stall cycles, flush or reset cancels what is left.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit hit;
    bit st;
    @(posedge clk);
    #1;
    rst_n = s.rst_n;
    ex_src_addr = s.ex_src;
    fwd_wr_en = s.wr_en;
    fwd_wr_addr = s.wr_addr;
    id_src_addr = s.id_src;
    id_src_used = s.id_used;
    ex_is_load = s.ex_is_load;
    ex_wr_en = s.ex_wr_en;
    ex_wr_addr = s.ex_wr_addr;
    flush = s.flush;
    hit = (s.id_used[0] && s.id_src[4:0] == s.ex_wr_addr) ||
          (s.id_used[1] && s.id_src[9:5] == s.ex_wr_addr);
    st = 1'b0;
    if (!s.rst_n) begin
      model_left = 0;
      model_count = 0;
    end else if (s.flush) begin
      model_left = 0;
    end else if (model_left > 0) begin
      st = 1'b1;
      model_left = model_left - 1;
    end else if (s.ex_is_load && s.ex_wr_en && s.ex_wr_addr != 5'd0 && hit) begin
      st = 1'b1;
      model_left = LOAD_LAT - 1;
    end
    e.sel = modelSel(s);
    e.stall = st;
    e.cnt = (model_count > 65535) ? 16'hFFFF : 16'(model_count);
    e.cnt_sat = (model_count > 3) ? 2'd3 : 2'(model_count);
    exp_q.push_back(e);
    if (s.rst_n && st) model_count = model_count + 1;
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (fwd_sel !== e.sel) begin
      errors++;
      $display("[TB] FAIL fwd_sel got %h exp %h at %0t", fwd_sel, e.sel, $time);
    end
    checks++;
    if ({pc_hold, ifid_hold, idex_bubble} !== {3{e.stall}}) begin
      errors++;
      $display("[TB] FAIL stall got %b%b%b exp %b at %0t", pc_hold, ifid_hold, idex_bubble, e.stall, $time);
    end
    checks++;
    if (stall_count !== e.cnt) begin
      errors++;
      $display("[TB] FAIL stall_count got %0d exp %0d at %0t", stall_count, e.cnt, $time);
    end
    checks++;
    if (sat_stall_count !== e.cnt_sat) begin
      errors++;
      $display("[TB] FAIL sat_count got %0d exp %0d at %0t", sat_stall_count, e.cnt_sat, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t loadHazard();
    stim_t s;
    s = idleStim();
    s.ex_is_load = 1'b1;
    s.ex_wr_en = 1'b1;
    s.ex_wr_addr = 5'd8;
    s.id_src = {5'd0, 5'd8};
    s.id_used = 2'b01;
    return s;
  endfunction

  initial begin : driver
    stim_t s;
    s = idleStim();
    s.rst_n = 1'b0;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idleStim());

    s = idleStim(); s.ex_src = {5'd5, 5'd5}; s.wr_en = 2'b11; s.wr_addr = {5'd5, 5'd5};
    applyStimulus(s);
    s.wr_en = 2'b10;
    applyStimulus(s);
    s = idleStim(); s.ex_src = {5'd3, 5'd0}; s.wr_en = 2'b11; s.wr_addr = {5'd0, 5'd0};
    applyStimulus(s);
    s = idleStim(); s.ex_src = {5'd0, 5'd7}; s.wr_en = 2'b00; s.wr_addr = {5'd7, 5'd7};
    applyStimulus(s);

    applyStimulus(loadHazard());
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    s = loadHazard(); s.id_used = 2'b00;
    applyStimulus(s);
    applyStimulus(idleStim());

    applyStimulus(loadHazard());
    s = idleStim(); s.flush = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());

    applyStimulus(loadHazard());
    s = idleStim(); s.rst_n = 1'b0;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());

    for (int n = 0; n < 3; n++) begin
      applyStimulus(loadHazard());
      applyStimulus(loadHazard());
    end
    applyStimulus(idleStim());

    for (int n = 0; n < 500; n++) begin
      s.rst_n = ($urandom_range(0, 63) != 0);
      s.ex_src = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      s.wr_en = 2'($urandom_range(0, 3));
      s.wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      s.id_src = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      s.id_used = 2'($urandom_range(0, 3));
      s.ex_is_load = 1'($urandom_range(0, 1));
      s.ex_wr_en = ($urandom_range(0, 3) != 0);
      s.ex_wr_addr = 5'($urandom_range(0, 7));
      s.flush = ($urandom_range(0, 7) == 0);
      applyStimulus(s);
    end
    driver_done = 1'b1;
  end

  initial begin : finisher
    wait (driver_done);
    for (int n = 0; n < 5 && exp_q.size() > 0; n++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL timeout got running exp finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised forwarding and load-use interlock unit for the pipelined MIPS core. It generalises operand forwarding to any number of source operands and producer stages, and qualifies every match on the producer's own write enable. It adds a sequential load-use stall controller that supports multi-cycle load latency, flush cancellation and a stall-cycle counter. It sits beside the ID/EX register and drives the EX operand muxes plus the PC, IF/ID hold and ID/EX bubble controls.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, source operands per instruction (Rs, Rt, ...)
NUM_FWD, 2, forwarding producer stages; index 0 = youngest (EX/MEM), 1 = MEM/WB, ...
LOAD_LAT, 2, bubbles required between a load in EX and a dependent consumer (>=1)
CNT_W, 16, stall counter width
SEL_W, clog2(NUM_FWD+1), derived; not overridable

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_src_addr  in  NUM_SRC*REG_AW  ID/EX source addresses, operand i at [i*REG_AW +: REG_AW]
fwd_wr_en  in  NUM_FWD  producer stage k writes a register
fwd_wr_addr  in  NUM_FWD*REG_AW  producer stage k destination
fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k+1 = stage k
id_src_addr  in  NUM_SRC*REG_AW  IF/ID source addresses
id_src_used  in  NUM_SRC  operand i actually read by ID instruction
ex_is_load  in  1  instruction in EX is a load
ex_wr_en  in  1  instruction in EX writes a register
ex_wr_addr  in  REG_AW  EX destination
flush  in  1  branch/jump flush of IF/ID and ID/EX this cycle
pc_hold  out  1  freeze PC
ifid_hold  out  1  freeze IF/ID
idex_bubble  out  1  load NOP into ID/EX
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Forwarding (combinational): for each operand i:
  - if ex_src_addr[i]==0, sel=0;
  - else sel = k+1 for the smallest k with fwd_wr_en[k] && fwd_wr_addr[k]==ex_src_addr[i];
  - no match -> 0.
  - The youngest producer always wins over older ones.
- Hazard term (combinational): haz = ex_is_load && ex_wr_en && ex_wr_addr!=0 && (OR over i of id_src_used[i] && id_src_addr[i]==ex_wr_addr).
- FSM states:
  - IDLE: stall = haz && !flush.
  - STALL: stall = !flush.
  - pc_hold = ifid_hold = idex_bubble = stall.
- Remaining counter rem, width clog2(LOAD_LAT)+1.
- IDLE -> STALL on haz && !flush && LOAD_LAT>1; load rem = LOAD_LAT-1.
- STALL: rem decrements each cycle. When rem==1, the next state is IDLE. STALL therefore lasts LOAD_LAT-1 cycles, giving LOAD_LAT total stall cycles per hazard.
- While in STALL, haz is ignored because the load has left EX.
- LOAD_LAT==1: the FSM never leaves IDLE, and the stall lasts a single cycle.
- flush has priority in any state: stall outputs are 0 that cycle, next state is IDLE, rem is cleared.
- On return to IDLE, a new haz in that same cycle is evaluated normally. Back-to-back load-use hazards stall again.
- stall_count increments by 1 on each cycle that stall==1 and saturates at all-ones. It never wraps.
- Reset (async, rst_n low): state = IDLE, rem = 0, stall_count = 0.
  - pc_hold, ifid_hold and idex_bubble are 0 while in reset.
  - fwd_sel follows its inputs, because it is purely combinational.
- Reset asserted mid-stall aborts the stall immediately. No residual hold after rst_n rises.
- The unit has no internal pipeline latency for forwarding. Stall outputs take effect in the detection cycle.

Test Plan:
- ex_src_addr={Rt=5,Rs=5}, fwd_wr_en=2'b11, fwd_wr_addr={5,5} -> both fwd_sel=1 (youngest wins); fwd_wr_en=2'b10 -> both fwd_sel=2.
- ex_src_addr Rs=0, fwd_wr_en=2'b11, fwd_wr_addr={0,0} -> fwd_sel=0; Rs=7 with fwd_wr_en=0, fwd_wr_addr=7 -> fwd_sel=0.
- Load in EX (ex_wr_addr=8), ID uses Rs=8 -> stall high for exactly 2 cycles (LOAD_LAT=2); stall_count goes 0->2; id_src_used=0 with addr 8 -> no stall.
- Hazard detected, then flush asserted in the second stall cycle -> stall outputs 0 that cycle, FSM in IDLE, stall_count=1.
- rst_n pulsed low mid-stall -> outputs 0 immediately, stall_count=0, no stall after release.
- CNT_W=2, force 5 stall cycles -> stall_count saturates at 3.
